alu_cmd_sender: RTL and testbench
=================================

Name: alu_cmd_sender

Overview:
- Host-side initiator for the UART ALU link.
- Takes one parallel request (operand A, operand B, opcode) and serialises it as three bytes, A then B then OP, to a UART transmitter. It then waits for the single result byte from a UART receiver.
- Returns the result, or a timeout indication, on a response port.
- Sits between a test/host controller and the uart_tx/uart_rx pair. It is the peer of the board-side block that collects A/B/OP and answers with the ALU result.

Parameters:
- NB_DATA, 8, UART byte width and operand width.
- NB_OP, 6, opcode width; zero-extended to NB_DATA when transmitted.
- TIMEOUT_CYCLES, 50000, clock cycles to wait for the result byte before giving up; must be ≥2.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block idle, request accepted on valid&ready.
- i_req_a  in  NB_DATA  operand A.
- i_req_b  in  NB_DATA  operand B.
- i_req_op  in  NB_OP  ALU opcode.
- o_tx_data  out  NB_DATA  byte to the UART transmitter.
- o_tx_start  out  1  one-cycle pulse launching o_tx_data.
- i_tx_done  in  1  one-cycle pulse: transmitter finished current byte.
- i_rx_valid  in  1  one-cycle pulse: receiver has a byte.
- i_rx_data  in  NB_DATA  received byte.
- o_rsp_valid  out  1  one-cycle pulse: o_rsp_data holds the ALU result.
- o_rsp_data  out  NB_DATA  last result byte.
- o_rsp_timeout  out  1  one-cycle pulse: no result within TIMEOUT_CYCLES.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- One clock domain (i_clk). Reset is asynchronous and active-low on i_reset_n. All state registers clear immediately on i_reset_n=0.
- Reset values:
  - state=IDLE; byte index=0; timer=0; captured A/B/OP=0.
  - o_tx_data=0, o_tx_start=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_timeout=0, o_busy=0.
  - o_req_ready=1 (decoded from state==IDLE).
- All outputs except o_req_ready and o_busy are registered. Those two decode the current state only.
- States: IDLE, SEND, WAIT_TX, WAIT_RSP.
- IDLE:
  - On i_req_valid=1 at an edge: capture A, B and {0,OP} into a 3-byte buffer; idx<=0; go to SEND.
  - Inputs are sampled only at that edge; later changes have no effect.
- SEND:
  - o_tx_data<=byte[idx]; o_tx_start<=1 for exactly one cycle; go to WAIT_TX.
  - First o_tx_start is high in the cycle after request acceptance (latency 1).
- WAIT_TX:
  - o_tx_data is held stable.
  - On i_tx_done with idx<2: idx<=idx+1, go to SEND.
  - On i_tx_done with idx==2: timer<=0, go to WAIT_RSP.
  - i_tx_done in any other state is ignored, including the SEND cycle itself.
- WAIT_RSP:
  - Timer increments each cycle.
  - On i_rx_valid: o_rsp_data<=i_rx_data; o_rsp_valid<=1 for one cycle; go to IDLE.
  - On timer==TIMEOUT_CYCLES-1 without i_rx_valid: o_rsp_timeout<=1 for one cycle; o_rsp_data unchanged; go to IDLE.
  - i_rx_valid in the same cycle as timer expiry: the result wins, and no timeout is raised.
- i_rx_valid outside WAIT_RSP is ignored: stray bytes are dropped and o_rsp_data is not modified.
- o_rsp_valid/o_rsp_timeout are high in the first IDLE cycle, so o_req_ready is already 1. A request presented in that cycle is accepted (back-to-back).
- Reset asserted mid-transfer: immediate return to IDLE, with no further o_tx_start. A transmitter byte already in flight is not the block's concern.
- Exactly three o_tx_start pulses per accepted request, never overlapping an outstanding byte.
- Timer width is $clog2(TIMEOUT_CYCLES). The timer saturates logically by leaving the state and never wraps.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE/SEND/WAIT_TX/WAIT_RSP).
  - Byte index constants (IDX_A=0, IDX_B=1, IDX_OP=2).
  - NB_OP.
- One natural sub-module, rsp_timer: clear/enable counter with an expiry pulse at TIMEOUT_CYCLES-1, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Req A=0x05, B=0x03, OP=6'h20; tx_done 10 cycles after each start; rx 0x08 → o_tx_data sequence 0x05, 0x03, 0x20; three start pulses; o_rsp_valid once with o_rsp_data=0x08; o_req_ready=1 in the same cycle.
- TIMEOUT_CYCLES=16; A=0xFF, B=0x01, OP=6'h22; no rx → o_rsp_timeout pulse exactly 16 cycles after entering WAIT_RSP; o_rsp_data keeps its previous value; o_rsp_valid stays 0.
- rx_valid with data 0x77 while IDLE and during WAIT_TX → ignored; a later result byte 0x02 is reported with o_rsp_data=0x02.
- Reset pulled low after the second o_tx_start → all outputs at reset values asynchronously; no third start; a new request 0x01/0x01/0x20 runs cleanly.
- i_rx_valid=1 (data 0x3C) in the expiry cycle with TIMEOUT_CYCLES=16 → o_rsp_valid=1, o_rsp_data=0x3C, o_rsp_timeout=0.
- Two requests held valid back-to-back → second accepted in the cycle o_rsp_valid is high; its first o_tx_start occurs in the next cycle.

Source files
------------

// File: rtl/alu_cmd_sender_pkg.sv
// ============================================================================
// alu_cmd_sender_pkg
// Shared state encoding, byte-slot indices and default opcode width.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_cmd_sender_pkg;

  localparam int NB_OP_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_TX  = 2'd2,
    ST_WAIT_RSP = 2'd3
  } state_e;

  localparam logic [1:0] IDX_A  = 2'd0;
  localparam logic [1:0] IDX_B  = 2'd1;
  localparam logic [1:0] IDX_OP = 2'd2;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_sender_if.sv
// ============================================================================
// alu_cmd_sender_if
// Request, UART tx/rx and response signals of the ALU command sender.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_cmd_sender_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = alu_cmd_sender_pkg::NB_OP_DEFAULT
) ();

  logic               i_req_valid;
  logic               o_req_ready;
  logic [NB_DATA-1:0] i_req_a;
  logic [NB_DATA-1:0] i_req_b;
  logic [NB_OP-1:0]   i_req_op;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_start;
  logic               i_tx_done;
  logic               i_rx_valid;
  logic [NB_DATA-1:0] i_rx_data;
  logic               o_rsp_valid;
  logic [NB_DATA-1:0] o_rsp_data;
  logic               o_rsp_timeout;
  logic               o_busy;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_req_op, i_tx_done, i_rx_valid, i_rx_data,
    output o_req_ready, o_tx_data, o_tx_start, o_rsp_valid, o_rsp_data, o_rsp_timeout, o_busy
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_req_op, i_tx_done, i_rx_valid, i_rx_data,
    input  o_req_ready, o_tx_data, o_tx_start, o_rsp_valid, o_rsp_data, o_rsp_timeout, o_busy
  );

endinterface

`default_nettype wire

// File: rtl/alu_cmd_sender_rsp_timer.sv
// ============================================================================
// alu_cmd_sender_rsp_timer
// Clear/enable response counter; o_expired flags the last allowed cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sender_rsp_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int                 NB_TIMER = $clog2(TIMEOUT_CYCLES);
  localparam logic [NB_TIMER-1:0] LAST    = NB_TIMER'(TIMEOUT_CYCLES - 1);

  logic [NB_TIMER-1:0] cnt_q, cnt_d;

  // The owner leaves its wait state on expiry, so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + NB_TIMER'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_en && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/alu_cmd_sender.sv
// ============================================================================
// alu_cmd_sender
// Sends A, B, OP as three UART bytes, then returns the result byte or a timeout.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_cmd_sender
  import alu_cmd_sender_pkg::*;
#(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = NB_OP_DEFAULT,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  alu_cmd_sender_if.slave bus
);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_DATA-1:0] rsp_data_q, rsp_data_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_timeout_q, rsp_timeout_d;
  logic               timer_clr;
  logic               timer_en;
  logic               timer_expired;
  logic [NB_DATA-1:0] cur_byte;

  always_comb begin
    cur_byte = NB_DATA'(op_q);
    case (idx_q)
      IDX_A:   cur_byte = a_q;
      IDX_B:   cur_byte = b_q;
      default: cur_byte = NB_DATA'(op_q);
    endcase
  end

  assign timer_en = (state_q == ST_WAIT_RSP);

  alu_cmd_sender_rsp_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rsp_timer (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clr    (timer_clr),
    .i_en     (timer_en),
    .o_expired(timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    rsp_data_d    = rsp_data_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    timer_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_req_valid) begin
          a_d     = bus.i_req_a;
          b_d     = bus.i_req_b;
          op_d    = bus.i_req_op;
          idx_d   = IDX_A;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_data_d  = cur_byte;
        tx_start_d = 1'b1;
        state_d    = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (bus.i_tx_done) begin
          if (idx_q == IDX_OP) begin
            timer_clr = 1'b1;
            state_d   = ST_WAIT_RSP;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_SEND;
          end
        end
      end
      ST_WAIT_RSP: begin
        // A result arriving on the expiry cycle takes precedence over the timeout.
        if (bus.i_rx_valid) begin
          rsp_data_d  = bus.i_rx_data;
          rsp_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (timer_expired) begin
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= IDX_A;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      rsp_data_q    <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      rsp_data_q    <= rsp_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign bus.o_req_ready   = (state_q == ST_IDLE);
  assign bus.o_busy        = (state_q != ST_IDLE);
  assign bus.o_tx_data     = tx_data_q;
  assign bus.o_tx_start    = tx_start_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_data    = rsp_data_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_sender.sv
// ============================================================================
// tb_alu_cmd_sender
// Scoreboard bench: expected tx bytes and responses are queued at stimulus time.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_cmd_sender;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TO      = 16;
  localparam int TX_LAT  = 10;

  typedef struct packed {
    logic       is_to;
    logic [7:0] data;
  } rsp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sender_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) bus ();

  alu_cmd_sender #(
    .NB_DATA       (NB_DATA),
    .NB_OP         (NB_OP),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];
  int errors = 0, checks = 0;
  int cyc = 0, n_start = 0, n_done = 0, n_rsp = 0, n_to = 0;
  int tx_pend = 0, last_done_cyc = 0, to_cyc = 0;
  logic [7:0] last_rsp = 8'h00;

  // Monitor plus transmitter model, ordered within one negedge process.
  initial begin
    logic [7:0] e;
    rsp_t       er;
    forever begin
      @(negedge clk);
      cyc++;
      bus.i_tx_done = 1'b0;
      if (!rst_n) begin
        tx_pend = 0;
      end else begin
        if (bus.o_tx_start === 1'b1) begin
          n_start++;
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: start with data %h, required no start", bus.o_tx_data);
          end else begin
            e = exp_tx.pop_front();
            if (bus.o_tx_data !== e) begin
              errors++;
              $display("FAIL tx_data: got %h, required %h", bus.o_tx_data, e);
            end
          end
          checks++;
          if (tx_pend != 0) begin
            errors++;
            $display("FAIL tx_overlap: start with %0d cycles outstanding, required 0", tx_pend);
          end
        end
        if (bus.o_rsp_valid === 1'b1) begin
          n_rsp++;
          checks++;
          if (exp_rsp.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: rsp_valid with data %h, required none", bus.o_rsp_data);
          end else begin
            er = exp_rsp.pop_front();
            if (er.is_to !== 1'b0 || bus.o_rsp_data !== er.data) begin
              errors++;
              $display("FAIL rsp_data: got valid data %h, required timeout=%0b data %h",
                       bus.o_rsp_data, er.is_to, er.data);
            end
            last_rsp = er.data;
          end
          checks++;
          if (bus.o_req_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL rsp_ready: got ready=%b busy=%b, required 1/0", bus.o_req_ready, bus.o_busy);
          end
        end
        if (bus.o_rsp_timeout === 1'b1) begin
          n_to++;
          to_cyc = cyc;
          checks++;
          if (exp_rsp.size() == 0) begin
            errors++;
            $display("FAIL to_unexpected: timeout pulse, required none");
          end else begin
            er = exp_rsp.pop_front();
            if (er.is_to !== 1'b1 || bus.o_rsp_data !== er.data || bus.o_rsp_valid !== 1'b0) begin
              errors++;
              $display("FAIL to_pulse: got data %h valid %b, required timeout=%0b data %h valid 0",
                       bus.o_rsp_data, bus.o_rsp_valid, er.is_to, er.data);
            end
          end
        end
        if (tx_pend > 0) begin
          tx_pend--;
          if (tx_pend == 0) begin
            bus.i_tx_done = 1'b1;
            n_done++;
            last_done_cyc = cyc;
          end
        end
        if (bus.o_tx_start === 1'b1) tx_pend = TX_LAT;
      end
    end
  end

  task automatic drive_req(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int n = 0;
    @(negedge clk);
    bus.i_req_valid = 1'b1;
    bus.i_req_a     = a;
    bus.i_req_b     = b;
    bus.i_req_op    = op;
    exp_tx.push_back(a);
    exp_tx.push_back(b);
    exp_tx.push_back({2'b00, op});
    while (bus.o_req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL req_accept: ready stayed %b, required 1", bus.o_req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    bus.i_req_a     = ~a;
    bus.i_req_b     = ~b;
    bus.i_req_op    = ~op;
    checks++;
    if (bus.o_tx_start !== 1'b0 || bus.o_busy !== 1'b1) begin
      errors++;
      $display("FAIL lat_accept: got start=%b busy=%b, required 0/1", bus.o_tx_start, bus.o_busy);
    end
    @(negedge clk);
    checks++;
    if (bus.o_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL lat_first_start: got %b, required 1", bus.o_tx_start);
    end
  endtask

  task automatic wait_dones(input int target);
    int n = 0;
    while (n_done < target && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n_done < target) begin
      errors++;
      $display("FAIL wait_tx_done: got %0d dones, required %0d", n_done, target);
    end
  endtask

  task automatic send_rx(input logic [7:0] d, input bit expect_rsp);
    @(negedge clk);
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = d;
    if (expect_rsp) exp_rsp.push_back('{is_to: 1'b0, data: d});
    @(negedge clk);
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL rsp_wait: %0d responses pending, required 0", exp_rsp.size());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0 ||
        bus.o_tx_data !== 8'h00 || bus.o_rsp_valid !== 1'b0 || bus.o_rsp_data !== 8'h00 ||
        bus.o_rsp_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b busy=%b st=%b txd=%h rv=%b rd=%h to=%b, required 1 0 0 00 0 00 0",
               bus.o_req_ready, bus.o_busy, bus.o_tx_start, bus.o_tx_data,
               bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_timeout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.o_busy !== 1'b0 || bus.o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: got busy=%b start=%b, required 0/0", bus.o_busy, bus.o_tx_start);
    end
  endtask

  task automatic test_basic();
    int s0 = n_start, d0 = n_done, r0 = n_rsp;
    drive_req(8'h05, 8'h03, 6'h20);
    wait_dones(d0 + 3);
    repeat (2) @(posedge clk);
    send_rx(8'h08, 1'b1);
    wait_drained();
    checks++;
    if (n_start - s0 != 3 || n_rsp - r0 != 1 || bus.o_rsp_data !== 8'h08) begin
      errors++;
      $display("FAIL basic: got starts=%0d rsps=%0d data=%h, required 3 1 08",
               n_start - s0, n_rsp - r0, bus.o_rsp_data);
    end
  endtask

  task automatic test_timeout();
    int d0 = n_done, r0 = n_rsp, t0 = n_to;
    logic [7:0] prev;
    prev = last_rsp;
    drive_req(8'hFF, 8'h01, 6'h22);
    wait_dones(d0 + 3);
    exp_rsp.push_back('{is_to: 1'b1, data: prev});
    wait_drained();
    checks++;
    if (n_to - t0 != 1 || n_rsp != r0) begin
      errors++;
      $display("FAIL timeout_count: got timeouts=%0d rsps=%0d, required 1 0", n_to - t0, n_rsp - r0);
    end
    checks++;
    if (to_cyc - last_done_cyc != TO + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d, required %0d", to_cyc - last_done_cyc - 1, TO);
    end
    checks++;
    if (bus.o_rsp_data !== prev) begin
      errors++;
      $display("FAIL timeout_data_kept: got %h, required %h", bus.o_rsp_data, prev);
    end
  endtask

  task automatic test_stray_rx();
    int d0, r0 = n_rsp;
    logic [7:0] prev;
    prev = last_rsp;
    send_rx(8'h77, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_rsp_data !== prev || n_rsp != r0) begin
      errors++;
      $display("FAIL stray_idle: got data %h rsps %0d, required %h 0", bus.o_rsp_data, n_rsp - r0, prev);
    end
    d0 = n_done;
    drive_req(8'h11, 8'h22, 6'h03);
    send_rx(8'h77, 1'b0);
    wait_dones(d0 + 3);
    send_rx(8'h02, 1'b1);
    wait_drained();
    checks++;
    if (bus.o_rsp_data !== 8'h02 || n_rsp - r0 != 1) begin
      errors++;
      $display("FAIL stray_wait_tx: got data %h rsps %0d, required 02 1", bus.o_rsp_data, n_rsp - r0);
    end
  endtask

  task automatic test_reset_mid();
    int s0 = n_start, n = 0, d1;
    drive_req(8'hAA, 8'hBB, 6'h0C);
    while (n_start < s0 + 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_busy !== 1'b0 || bus.o_tx_data !== 8'h00 ||
        bus.o_tx_start !== 1'b0 || bus.o_rsp_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got rdy=%b busy=%b txd=%h st=%b rd=%h, required 1 0 00 0 00",
               bus.o_req_ready, bus.o_busy, bus.o_tx_data, bus.o_tx_start, bus.o_rsp_data);
    end
    exp_tx.delete();
    last_rsp = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (n_start != s0 + 2) begin
      errors++;
      $display("FAIL reset_no_third: got %0d starts, required 2", n_start - s0);
    end
    d1 = n_done;
    drive_req(8'h01, 8'h01, 6'h20);
    wait_dones(d1 + 3);
    send_rx(8'h5A, 1'b1);
    wait_drained();
    checks++;
    if (n_start != s0 + 5 || bus.o_rsp_data !== 8'h5A) begin
      errors++;
      $display("FAIL reset_recover: got starts=%0d data=%h, required 3 5a", n_start - s0 - 2, bus.o_rsp_data);
    end
  endtask

  task automatic test_expiry_rx();
    int d0 = n_done, t0 = n_to;
    drive_req(8'h10, 8'h20, 6'h01);
    wait_dones(d0 + 3);
    repeat (TO - 1) @(posedge clk);
    send_rx(8'h3C, 1'b1);
    wait_drained();
    checks++;
    if (n_to != t0 || bus.o_rsp_data !== 8'h3C) begin
      errors++;
      $display("FAIL expiry_rx: got timeouts=%0d data=%h, required 0 3c", n_to - t0, bus.o_rsp_data);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = n_start, d0 = n_done, n = 0;
    drive_req(8'h21, 8'h22, 6'h01);
    bus.i_req_valid = 1'b1;
    bus.i_req_a     = 8'h31;
    bus.i_req_b     = 8'h32;
    bus.i_req_op    = 6'h02;
    exp_tx.push_back(8'h31);
    exp_tx.push_back(8'h32);
    exp_tx.push_back(8'h02);
    wait_dones(d0 + 3);
    send_rx(8'h40, 1'b1);
    while (bus.o_rsp_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.o_rsp_valid !== 1'b1 || bus.o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: got valid=%b ready=%b, required 1/1", bus.o_rsp_valid, bus.o_req_ready);
    end
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    checks++;
    if (bus.o_busy !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got busy=%b start=%b, required 1/0", bus.o_busy, bus.o_tx_start);
    end
    @(negedge clk);
    checks++;
    if (bus.o_tx_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_first_start: got %b, required 1", bus.o_tx_start);
    end
    wait_dones(d0 + 6);
    send_rx(8'h41, 1'b1);
    wait_drained();
    checks++;
    if (n_start - s0 != 6 || bus.o_rsp_data !== 8'h41) begin
      errors++;
      $display("FAIL b2b_total: got starts=%0d data=%h, required 6 41", n_start - s0, bus.o_rsp_data);
    end
  endtask

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_a     = 8'h00;
    bus.i_req_b     = 8'h00;
    bus.i_req_op    = 6'h00;
    bus.i_tx_done   = 1'b0;
    bus.i_rx_valid  = 1'b0;
    bus.i_rx_data   = 8'h00;
    test_reset();
    test_basic();
    test_timeout();
    test_stray_rx();
    test_reset_mid();
    test_expiry_rx();
    test_back_to_back();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_tx.size() != 0 || exp_rsp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got tx=%0d rsp=%0d pending, required 0 0", exp_tx.size(), exp_rsp.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
